// File: rtl/board_renderer_if.sv
// Pixel write bus between the board renderer and the 160x120 VGA adapter.
interface board_renderer_if;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;

    modport master (output x, output y, output colour, output plot, input busy);
    modport slave  (input x, input y, input colour, input plot, output busy);
endinterface

// File: rtl/board_renderer.sv
// Board renderer: snapshots the Gomoku board each frame and streams one pixel per
// accepted cycle (cell-major, then row, then column) to the VGA adapter.
module board_renderer #(
    parameter int unsigned CELL_PX  = 7,
    parameter int unsigned OFFSET_X = 24,
    parameter int unsigned OFFSET_Y = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [511:0]             board,
    input  logic [3:0]               pointer_x,
    input  logic [3:0]               pointer_y,
    input  logic [1:0]               game_state,
    board_renderer_if.master         vga,
    output logic                     frame_done,
    output logic                     drawing
);

    localparam logic [2:0] PxMax = 3'(CELL_PX - 1);

    typedef enum logic [1:0] {StIdle, StLatch, StDraw, StDone} state_e;

    state_e       state_q;
    logic [511:0] board_q;
    logic [3:0]   ptr_x_q, ptr_y_q;
    logic [1:0]   gs_q;
    logic [7:0]   idx_q;
    logic [2:0]   px_q, py_q;
    logic [7:0]   x_q;
    logic [6:0]   y_q;
    logic [2:0]   colour_q;
    logic         plot_q, frame_done_q, drawing_q;

    logic [7:0]   idx_nxt;
    logic [2:0]   px_nxt, py_nxt;
    logic         last_px;

    logic [7:0]   pos_idx;
    logic [2:0]   pos_px, pos_py;
    logic [1:0]   pos_cell;
    logic         pos_border, pos_on_ptr;
    logic [7:0]   pix_x_d;
    logic [6:0]   pix_y_d;
    logic [2:0]   pix_col_d;

    // Counter advance: px minor, py major within a cell, then next cell.
    always_comb begin
        px_nxt  = px_q + 3'd1;
        py_nxt  = py_q;
        idx_nxt = idx_q;
        last_px = 1'b0;
        if (px_q == PxMax) begin
            px_nxt = 3'd0;
            py_nxt = py_q + 3'd1;
            if (py_q == PxMax) begin
                py_nxt  = 3'd0;
                idx_nxt = idx_q + 8'd1;
                last_px = (idx_q == 8'hff);
            end
        end
    end

    // Pixel to present next: the frame origin when leaving LATCH, else the advanced position.
    always_comb begin
        pos_idx = (state_q == StLatch) ? 8'd0 : idx_nxt;
        pos_px  = (state_q == StLatch) ? 3'd0 : px_nxt;
        pos_py  = (state_q == StLatch) ? 3'd0 : py_nxt;

        pix_x_d = 8'(OFFSET_X) + 8'(pos_idx[3:0]) * 8'(CELL_PX) + 8'(pos_px);
        pix_y_d = 7'(OFFSET_Y) + 7'(pos_idx[7:4]) * 7'(CELL_PX) + 7'(pos_py);

        pos_cell   = board_q[{pos_idx, 1'b0} +: 2];
        pos_border = (pos_px == 3'd0) || (pos_py == 3'd0);
        pos_on_ptr = (pos_idx[3:0] == ptr_x_q) && (pos_idx[7:4] == ptr_y_q);

        pix_col_d = 3'b010;
        if (pos_border) begin
            if (pos_on_ptr) begin
                pix_col_d = 3'b100;
            end else begin
                unique case (gs_q)
                    2'b01:   pix_col_d = 3'b000;
                    2'b10:   pix_col_d = 3'b111;
                    default: pix_col_d = 3'b010;
                endcase
            end
        end else begin
            unique case (pos_cell)
                2'b00:   pix_col_d = 3'b110;
                2'b01:   pix_col_d = 3'b000;
                2'b10:   pix_col_d = 3'b111;
                default: pix_col_d = 3'b101;
            endcase
        end
    end

    // Frame FSM with registered pixel outputs; outputs hold while the adapter stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            board_q      <= '0;
            ptr_x_q      <= '0;
            ptr_y_q      <= '0;
            gs_q         <= '0;
            idx_q        <= '0;
            px_q         <= '0;
            py_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
            plot_q       <= 1'b0;
            frame_done_q <= 1'b0;
            drawing_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (enable) begin
                        state_q   <= StLatch;
                        board_q   <= board;
                        ptr_x_q   <= pointer_x;
                        ptr_y_q   <= pointer_y;
                        gs_q      <= game_state;
                        idx_q     <= '0;
                        px_q      <= '0;
                        py_q      <= '0;
                        drawing_q <= 1'b1;
                    end
                end
                StLatch: begin
                    state_q  <= StDraw;
                    x_q      <= pix_x_d;
                    y_q      <= pix_y_d;
                    colour_q <= pix_col_d;
                    plot_q   <= 1'b1;
                end
                StDraw: begin
                    if (!vga.busy) begin
                        if (last_px) begin
                            state_q      <= StDone;
                            plot_q       <= 1'b0;
                            frame_done_q <= 1'b1;
                            drawing_q    <= 1'b0;
                        end else begin
                            idx_q    <= idx_nxt;
                            px_q     <= px_nxt;
                            py_q     <= py_nxt;
                            x_q      <= pix_x_d;
                            y_q      <= pix_y_d;
                            colour_q <= pix_col_d;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign vga.x      = x_q;
    assign vga.y      = y_q;
    assign vga.colour = colour_q;
    assign vga.plot   = plot_q;
    assign frame_done = frame_done_q;
    assign drawing    = drawing_q;

endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer: frame length, colours, stall, snapshot and reset abort.
module tb_board_renderer;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic [511:0] board = '0;
    logic [3:0]   pointer_x = '0;
    logic [3:0]   pointer_y = '0;
    logic [1:0]   game_state = '0;
    logic         frame_done;
    logic         drawing;

    int n_total = 0;
    int n_pass  = 0;
    int acc_cnt = 0;
    int fd_cnt  = 0;

    board_renderer_if bus ();

    board_renderer #(
        .CELL_PX  (7),
        .OFFSET_X (24),
        .OFFSET_Y (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .board      (board),
        .pointer_x  (pointer_x),
        .pointer_y  (pointer_y),
        .game_state (game_state),
        .vga        (bus),
        .frame_done (frame_done),
        .drawing    (drawing)
    );

    always #5 clk = ~clk;

    // Accepted-pixel and frame_done pulse counters.
    always @(posedge clk) begin
        if (bus.plot === 1'b1 && bus.busy === 1'b0) acc_cnt <= acc_cnt + 1;
        if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        enable     = 1'b0;
        bus.busy   = 1'b0;
        board      = '0;
        pointer_x  = '0;
        pointer_y  = '0;
        game_state = '0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic wait_pixel(input logic [7:0] ex, input logic [6:0] ey,
                              output logic [2:0] col, output bit found);
        found = 1'b0;
        col   = 3'bxxx;
        for (int i = 0; i < 14000; i++) begin
            if (bus.plot === 1'b1 && bus.busy === 1'b0 && bus.x === ex && bus.y === ey) begin
                found = 1'b1;
                col   = bus.colour;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        step();
        n_total++;
        if ({bus.x, bus.y, bus.colour, bus.plot, frame_done, drawing} !== 21'd0)
            $display("FAIL reset_outputs: got x=%0d y=%0d c=%b plot=%b fd=%b drw=%b, want all 0",
                     bus.x, bus.y, bus.colour, bus.plot, frame_done, drawing);
        else n_pass++;
        reset = 1'b1;
        for (int i = 0; i < 20; i++) step();
        n_total++;
        if (bus.plot !== 1'b0 || drawing !== 1'b0)
            $display("FAIL idle_disabled: got plot=%b drawing=%b, want 0 0", bus.plot, drawing);
        else n_pass++;
    endtask

    task automatic test_full_frame();
        int n_plot;
        do_reset();
        enable = 1'b1;
        step();
        n_total++;
        if (drawing !== 1'b1 || bus.plot !== 1'b0)
            $display("FAIL latch_state: got drawing=%b plot=%b, want 1 0", drawing, bus.plot);
        else n_pass++;
        step();
        n_total++;
        if (bus.plot !== 1'b1 || bus.x !== 8'd24 || bus.y !== 7'd4 || bus.colour !== 3'b100)
            $display("FAIL first_pixel: got plot=%b x=%0d y=%0d c=%b, want 1 24 4 100",
                     bus.plot, bus.x, bus.y, bus.colour);
        else n_pass++;
        n_plot = 0;
        for (int i = 0; i < 13000; i++) begin
            if (frame_done === 1'b1) break;
            if (bus.plot === 1'b1) n_plot++;
            step();
        end
        n_total++;
        if (n_plot !== 12544)
            $display("FAIL frame_pixels: got %0d, want 12544", n_plot);
        else n_pass++;
        n_total++;
        if (frame_done !== 1'b1 || bus.plot !== 1'b0)
            $display("FAIL done_pulse: got fd=%b plot=%b, want 1 0", frame_done, bus.plot);
        else n_pass++;
        step();
        n_total++;
        if (frame_done !== 1'b0 || drawing !== 1'b0)
            $display("FAIL done_one_cycle: got fd=%b drawing=%b, want 0 0", frame_done, drawing);
        else n_pass++;
        step();
        n_total++;
        if (drawing !== 1'b1)
            $display("FAIL restart_latch: got drawing=%b, want 1", drawing);
        else n_pass++;
    endtask

    task automatic test_colours();
        logic [2:0] col;
        bit         found;
        do_reset();
        board[35:34] = 2'b01;
        pointer_x    = 4'd5;
        pointer_y    = 4'd5;
        enable       = 1'b1;
        wait_pixel(8'd31, 7'd11, col, found);
        n_total++;
        if (!found || col !== 3'b010)
            $display("FAIL grid_border: found=%b colour=%b, want 1 010", found, col);
        else n_pass++;
        wait_pixel(8'd34, 7'd14, col, found);
        n_total++;
        if (!found || col !== 3'b000)
            $display("FAIL black_interior: found=%b colour=%b, want 1 000", found, col);
        else n_pass++;
        wait_pixel(8'd59, 7'd39, col, found);
        n_total++;
        if (!found || col !== 3'b100)
            $display("FAIL pointer_border: found=%b colour=%b, want 1 100", found, col);
        else n_pass++;
    endtask

    task automatic test_busy_stall();
        int acc0;
        int cyc;
        do_reset();
        enable = 1'b1;
        step();
        step();
        acc0 = acc_cnt;
        for (int i = 0; i < 10; i++) step();
        bus.busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_total++;
            if (bus.plot !== 1'b1 || bus.x !== 8'd27 || bus.y !== 7'd5 || bus.colour !== 3'b110)
                $display("FAIL stall_hold: got plot=%b x=%0d y=%0d c=%b, want 1 27 5 110",
                         bus.plot, bus.x, bus.y, bus.colour);
            else n_pass++;
        end
        bus.busy = 1'b0;
        enable   = 1'b0;
        step();
        n_total++;
        if (bus.x !== 8'd28 || bus.y !== 7'd5)
            $display("FAIL stall_resume: got x=%0d y=%0d, want 28 5", bus.x, bus.y);
        else n_pass++;
        cyc = 16;
        for (int i = 0; i < 13000; i++) begin
            if (frame_done === 1'b1) break;
            step();
            cyc++;
        end
        n_total++;
        if (cyc !== 12549)
            $display("FAIL stall_done_time: got cycle %0d, want 12549", cyc);
        else n_pass++;
        n_total++;
        if (acc_cnt - acc0 !== 12544)
            $display("FAIL stall_accepted: got %0d, want 12544", acc_cnt - acc0);
        else n_pass++;
        step();
        step();
        step();
        n_total++;
        if (drawing !== 1'b0 || bus.plot !== 1'b0)
            $display("FAIL stays_idle: got drawing=%b plot=%b, want 0 0", drawing, bus.plot);
        else n_pass++;
    endtask

    task automatic test_snapshot();
        logic [2:0] col;
        bit         found;
        do_reset();
        enable = 1'b1;
        wait_pixel(8'd25, 7'd5, col, found);
        n_total++;
        if (!found || col !== 3'b110)
            $display("FAIL snap_cell0_before: found=%b colour=%b, want 1 110", found, col);
        else n_pass++;
        wait_pixel(8'd52, 7'd46, col, found);
        board[1:0]     = 2'b10;
        board[401:400] = 2'b01;
        wait_pixel(8'd83, 7'd91, col, found);
        n_total++;
        if (!found || col !== 3'b110)
            $display("FAIL snap_cell200_current: found=%b colour=%b, want 1 110", found, col);
        else n_pass++;
        wait_pixel(8'd25, 7'd5, col, found);
        n_total++;
        if (!found || col !== 3'b111)
            $display("FAIL snap_cell0_next: found=%b colour=%b, want 1 111", found, col);
        else n_pass++;
        wait_pixel(8'd83, 7'd91, col, found);
        n_total++;
        if (!found || col !== 3'b000)
            $display("FAIL snap_cell200_next: found=%b colour=%b, want 1 000", found, col);
        else n_pass++;
    endtask

    task automatic test_game_state();
        logic [2:0] col;
        bit         found;
        do_reset();
        game_state     = 2'b10;
        board[511:510] = 2'b11;
        enable         = 1'b1;
        wait_pixel(8'd24, 7'd4, col, found);
        n_total++;
        if (!found || col !== 3'b100)
            $display("FAIL gs_pointer: found=%b colour=%b, want 1 100", found, col);
        else n_pass++;
        wait_pixel(8'd31, 7'd4, col, found);
        n_total++;
        if (!found || col !== 3'b111)
            $display("FAIL gs_cell1_corner: found=%b colour=%b, want 1 111", found, col);
        else n_pass++;
        wait_pixel(8'd32, 7'd4, col, found);
        n_total++;
        if (!found || col !== 3'b111)
            $display("FAIL gs_cell1_top: found=%b colour=%b, want 1 111", found, col);
        else n_pass++;
        wait_pixel(8'd129, 7'd109, col, found);
        n_total++;
        if (!found || col !== 3'b111)
            $display("FAIL gs_cell255_border: found=%b colour=%b, want 1 111", found, col);
        else n_pass++;
        wait_pixel(8'd132, 7'd112, col, found);
        n_total++;
        if (!found || col !== 3'b101)
            $display("FAIL invalid_interior: found=%b colour=%b, want 1 101", found, col);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        int fd0;
        do_reset();
        enable = 1'b1;
        step();
        step();
        for (int i = 0; i < 5000; i++) step();
        fd0   = fd_cnt;
        reset = 1'b0;
        #1;
        n_total++;
        if (bus.plot !== 1'b0 || drawing !== 1'b0)
            $display("FAIL abort_async: got plot=%b drawing=%b, want 0 0", bus.plot, drawing);
        else n_pass++;
        step();
        step();
        reset = 1'b1;
        step();
        step();
        n_total++;
        if (bus.plot !== 1'b1 || bus.x !== 8'd24 || bus.y !== 7'd4 || bus.colour !== 3'b100)
            $display("FAIL abort_restart: got plot=%b x=%0d y=%0d c=%b, want 1 24 4 100",
                     bus.plot, bus.x, bus.y, bus.colour);
        else n_pass++;
        n_total++;
        if (fd_cnt !== fd0)
            $display("FAIL abort_no_done: got %0d pulses, want 0", fd_cnt - fd0);
        else n_pass++;
    endtask

    initial begin
        bus.busy = 1'b0;
        test_reset();
        test_full_frame();
        test_colours();
        test_busy_stall();
        test_snapshot();
        test_game_state();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
